// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: accepts one field set, emits one word with its address.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              done
);

  localparam logic [31:0] Nop    = 32'h0000_0033;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  localparam logic [6:0] OpAluReg = 7'b0110011;
  localparam logic [6:0] OpAluImm = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [3:0] KAluReg = 4'd0;
  localparam logic [3:0] KAluImm = 4'd1;
  localparam logic [3:0] KBranch = 4'd2;
  localparam logic [3:0] KJalr   = 4'd3;
  localparam logic [3:0] KJal    = 4'd4;
  localparam logic [3:0] KAuipc  = 4'd5;
  localparam logic [3:0] KLui    = 4'd6;
  localparam logic [3:0] KLoad   = 4'd7;
  localparam logic [3:0] KStore  = 4'd8;
  localparam logic [3:0] KSystem = 4'd9;

  typedef enum logic [1:0] {StAccept, StOutput, StStop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic              sys_q, sys_d;

  logic [31:0]       enc_instr;
  logic              enc_err;
  logic              range_bad;

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               i_bad, b_bad, j_bad, u_bad;

  assign simm  = $signed(in_imm);
  assign i_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
  assign b_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
  assign j_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
  assign u_bad = (in_imm[11:0] != 12'h000);

  always_comb begin
    range_bad = 1'b0;
    case (in_kind)
      KAluImm, KJalr, KLoad, KStore: range_bad = i_bad;
      KBranch:                       range_bad = b_bad;
      KJal:                          range_bad = j_bad;
      KAuipc, KLui:                  range_bad = u_bad;
      default:                       range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  always_comb begin
    enc_instr = Nop;
    enc_err   = 1'b0;
    case (in_kind)
      KAluReg: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OpAluReg};
      KAluImm: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpAluImm};
      KLoad:   enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpLoad};
      KJalr:   enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, OpJalr};
      KStore:  enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OpStore};
      KBranch: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OpBranch};
      KLui:    enc_instr = {in_imm[31:12], in_rd, OpLui};
      KAuipc:  enc_instr = {in_imm[31:12], in_rd, OpAuipc};
      KJal:    enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpJal};
      KSystem: enc_instr = Ebreak;
      default: begin
        enc_instr = Nop;
        enc_err   = 1'b1;
      end
    endcase
    if (range_bad) begin
      enc_instr = Nop;
      enc_err   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    sys_d   = sys_q;
    case (state_q)
      StAccept: begin
        if (in_valid) begin
          instr_d = enc_instr;
          err_d   = enc_err;
          addr_d  = cnt_q;
          sys_d   = (in_kind == KSystem);
          state_d = StOutput;
        end
      end
      StOutput: begin
        if (out_ready) begin
          // The counter saturates at the last address; the program closes there.
          if (sys_q || (cnt_q == '1)) begin
            state_d = StStop;
          end else begin
            state_d = StAccept;
          end
          if (cnt_q != '1) cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StStop:   state_d = StStop;
      default:  state_d = StAccept;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StAccept;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= Nop;
      err_q   <= 1'b0;
      sys_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      sys_q   <= sys_d;
    end
  end

  assign in_ready  = (state_q == StAccept);
  assign out_valid = (state_q == StOutput);
  assign done      = (state_q == StStop);
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (ADDR_W=2): directed literal checks, then random traffic
// compared every cycle against an arithmetic reference model.
module tb_instr_encoder;

  localparam int AW = 2;
  localparam int LAST = (1 << AW) - 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          in_valid, in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err, done;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field arithmetic.
  function automatic logic [31:0] model_enc(input int kind, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm, output bit err);
    logic [31:0] w;
    int s;
    bit bad;
    s   = signed'(imm);
    bad = 0;
    err = 0;
    case (kind)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      7: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      8: w = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((imm & 32'h1f) << 7) | 32'h23;
      2: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
             | (((imm >> 11) & 1) << 7) | 32'h63;
      6: w = (imm & 32'hfffff000) | (rd << 7) | 32'h37;
      5: w = (imm & 32'hfffff000) | (rd << 7) | 32'h17;
      4: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
      9: w = 32'h00100073;
      default: begin w = 32'h33; err = 1; end
    endcase
`ifdef ENCODER_RANGE_CHECK_EN
    if (kind == 1 || kind == 3 || kind == 7 || kind == 8) bad = (s < -2048) || (s > 2047);
    if (kind == 2) bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
    if (kind == 4) bad = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (s % 2 != 0);
    if (kind == 5 || kind == 6) bad = (imm & 32'hfff) != 0;
`endif
    if (bad) begin w = 32'h33; err = 1; end
    return w;
  endfunction

  // Model: phase 0 accept, 1 output, 2 stop.
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_addr = 0;
  logic [31:0] m_word = 32'h33;
  bit          m_err = 0, m_sys = 0, m_live = 0, m_fresh = 0;

  always @(posedge CLK) begin
    bit e;
    if (RESET) begin
      m_phase = 0; m_cnt = 0; m_addr = 0; m_word = 32'h33; m_err = 0;
      m_live = 1; m_fresh = 1;
    end else if (m_live) begin
      if (m_phase == 0 && in_valid) begin
        m_word  = model_enc(int'(in_kind), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                            32'(in_funct3), 32'(in_funct7), in_imm, e);
        m_err   = e;
        m_addr  = m_cnt;
        m_sys   = (in_kind == 4'd9);
        m_phase = 1;
        m_fresh = 0;
      end else if (m_phase == 1 && out_ready) begin
        m_phase = (m_sys || m_cnt == LAST) ? 2 : 0;
        if (m_cnt < LAST) m_cnt++;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_phase == 2));
      if (m_phase == 1 || m_fresh) begin
        chk("out_instr", out_instr, m_word);
        chk("out_addr", 32'(out_addr), 32'(m_addr));
        chk("out_err", 32'(out_err), 32'(m_err));
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1; in_valid = 0; out_ready = 0;
    @(negedge CLK);
    RESET = 0;
  endtask

  task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input logic [31:0] imm);
    @(negedge CLK);
    in_kind = 4'(kind); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = imm; in_valid = 1;
    @(negedge CLK);
    in_valid = 0;
  endtask

  task automatic expect_word(input string name, input logic [31:0] w, input int a, input bit e);
    chk({name, ".instr"}, out_instr, w);
    chk({name, ".addr"}, 32'(out_addr), 32'(a));
    chk({name, ".err"}, 32'(out_err), 32'(e));
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    out_ready = 1;
    @(negedge CLK);
    out_ready = 0;
  endtask

  initial begin
    RESET = 1; in_valid = 0; out_ready = 0; in_kind = 0; in_rd = 0; in_rs1 = 0;
    in_rs2 = 0; in_funct3 = 0; in_funct7 = 0; in_imm = 0;
    do_reset();
    chk("rst.instr", out_instr, 32'h33);
    chk("rst.addr", 32'(out_addr), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.ready", 32'(in_ready), 1);

    send(1, 1, 1, 0, 0, 0, 32'd1);
    expect_word("addi", 32'h00108093, 0, 0);
    take();

    do_reset();
    send(0, 1, 0, 0, 0, 0, 32'd0); expect_word("add", 32'h000000B3, 0, 0); take();
    send(7, 2, 1, 0, 2, 0, 32'd0); expect_word("lw", 32'h0000A103, 1, 0); take();
    send(8, 0, 1, 2, 2, 0, 32'd0); expect_word("sw", 32'h0020A023, 2, 0); take();

    // Stall three cycles with a new field set offered; word must hold.
    send(1, 1, 1, 0, 0, 0, 32'd1);
    in_valid = 1; in_kind = 4'd0;
    for (int i = 0; i < 3; i++) begin
      expect_word("stall", 32'h00108093, 3, 0);
      chk("stall.ready", 32'(in_ready), 0);
      @(negedge CLK);
    end
    in_valid = 0;
    take();
    chk("last.done", 32'(done), 1);
    in_valid = 1;
    @(negedge CLK);
    chk("last.ready", 32'(in_ready), 0);
    in_valid = 0;

    do_reset();
    send(9, 3, 4, 5, 1, 9, 32'h1234);
    expect_word("ebreak", 32'h00100073, 0, 0);
    take();
    in_valid = 1;
    @(negedge CLK);
    chk("sys.done", 32'(done), 1);
    chk("sys.ready", 32'(in_ready), 0);
    do_reset();
    chk("sys.rst.done", 32'(done), 0);
    chk("sys.rst.addr", 32'(out_addr), 0);

    send(1, 1, 1, 0, 0, 0, 32'd2048);
`ifdef ENCODER_RANGE_CHECK_EN
    expect_word("addi2048", 32'h00000033, 0, 1);
`else
    expect_word("addi2048", 32'h80008093, 0, 0);
`endif
    take();
    send(12, 1, 2, 3, 4, 5, 32'hffff);
    expect_word("illegal", 32'h00000033, 1, 1);
    take();

    // Random traffic; the model compare process does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int sel;
      @(negedge CLK);
      RESET = ($urandom_range(0, (m_phase == 2) ? 3 : 60) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_kind   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: in_imm = 32'($urandom_range(0, 12000)) - 32'd6000;
        2: in_imm = $urandom & 32'hfffff000;
        default: in_imm = $urandom;
      endcase
    end
    RESET = 0;
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
